// File: rtl/rename_map_table.sv
// +------------------------------------------------------------------------+
// | rename_map_table: speculative/architectural register rename map table  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module rename_map_table #(
  parameter  int WIDTH    = 2,
  parameter  int AREG_NUM = 32,
  parameter  int PRF_SIZE = 64,
  localparam int PW       = $clog2(PRF_SIZE),
  localparam int AW       = $clog2(AREG_NUM)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          disp_en,
  input  logic [WIDTH-1:0]          dest_valid,
  input  logic [WIDTH-1:0][AW-1:0]  dest_areg,
  input  logic [WIDTH-1:0][AW-1:0]  src1_areg,
  input  logic [WIDTH-1:0][AW-1:0]  src2_areg,
  input  logic [WIDTH-1:0][PW-1:0]  free_preg,
  output logic [WIDTH-1:0][PW-1:0]  src1_preg,
  output logic [WIDTH-1:0][PW-1:0]  src2_preg,
  output logic [WIDTH-1:0]          src1_ready,
  output logic [WIDTH-1:0]          src2_ready,
  output logic [WIDTH-1:0][PW-1:0]  told,
  input  logic [WIDTH-1:0]          cdb_valid,
  input  logic [WIDTH-1:0][PW-1:0]  cdb_preg,
  input  logic [WIDTH-1:0]          retire_en,
  input  logic [WIDTH-1:0][AW-1:0]  retire_areg,
  input  logic [WIDTH-1:0][PW-1:0]  retire_preg,
  input  logic                      rollback_en
);

  localparam logic [PRF_SIZE-1:0] READY_INIT =
    {{(PRF_SIZE-AREG_NUM){1'b0}}, {AREG_NUM{1'b1}}};

  typedef struct packed {
    logic [PW-1:0] tag;
    logic          fwd;
  } lookup_t;

  logic [PW-1:0]       spec_map [AREG_NUM];
  logic [PW-1:0]       arch_map [AREG_NUM];
  logic [PW-1:0]       spec_nxt [AREG_NUM];
  logic [PW-1:0]       arch_nxt [AREG_NUM];
  logic [PRF_SIZE-1:0] prf_ready;
  logic [PRF_SIZE-1:0] ready_nxt;
  logic [WIDTH-1:0]    real_wr;

  // Map lookup with forwarding from older real writers in the same group;
  // the youngest older writer wins.
  function automatic lookup_t lookup(input logic [AW-1:0] areg, input int way);
    lookup_t r;
    r.tag = spec_map[areg];
    r.fwd = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < way && real_wr[j] && dest_areg[j] == areg) begin
        r.tag = free_preg[j];
        r.fwd = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic cdb_hit(input logic [PW-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (cdb_valid[j] && cdb_preg[j] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  for (genvar k = 0; k < WIDTH; k++) begin : g_way
    lookup_t s1_l;
    lookup_t s2_l;
    lookup_t d_l;

    assign real_wr[k] = disp_en[k] && dest_valid[k] && (dest_areg[k] != '0);

    assign s1_l = lookup(src1_areg[k], k);
    assign s2_l = lookup(src2_areg[k], k);
    assign d_l  = lookup(dest_areg[k], k);

    assign src1_preg[k]  = (src1_areg[k] == '0) ? '0 : s1_l.tag;
    assign src2_preg[k]  = (src2_areg[k] == '0) ? '0 : s2_l.tag;
    // A tag forwarded from this group is freshly allocated, so never ready.
    assign src1_ready[k] = (src1_areg[k] == '0) ||
                           (!s1_l.fwd && (prf_ready[s1_l.tag] || cdb_hit(s1_l.tag)));
    assign src2_ready[k] = (src2_areg[k] == '0) ||
                           (!s2_l.fwd && (prf_ready[s2_l.tag] || cdb_hit(s2_l.tag)));
    assign told[k]       = real_wr[k] ? d_l.tag : '0;
  end

  always_comb begin
    arch_nxt = arch_map;
    for (int k = 0; k < WIDTH; k++) begin
      if (retire_en[k] && retire_areg[k] != '0) arch_nxt[retire_areg[k]] = retire_preg[k];
    end
  end

  // Rollback restores from the post-retire architectural map and drops dispatch.
  always_comb begin
    spec_nxt = spec_map;
    if (rollback_en) begin
      spec_nxt = arch_nxt;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (real_wr[k]) spec_nxt[dest_areg[k]] = free_preg[k];
      end
    end
  end

  always_comb begin
    ready_nxt = prf_ready;
    for (int k = 0; k < WIDTH; k++) begin
      if (cdb_valid[k]) ready_nxt[cdb_preg[k]] = 1'b1;
    end
    if (rollback_en) begin
      for (int i = 0; i < AREG_NUM; i++) ready_nxt[arch_nxt[i]] = 1'b1;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (real_wr[k]) ready_nxt[free_preg[k]] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < AREG_NUM; i++) begin
        spec_map[i] <= PW'(i);
        arch_map[i] <= PW'(i);
      end
      prf_ready <= READY_INIT;
    end else begin
      spec_map  <= spec_nxt;
      arch_map  <= arch_nxt;
      prf_ready <= ready_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table using an expectation scoreboard.
`default_nettype none

module tb_rename_map_table;
  localparam int WIDTH = 2;
  localparam int PW    = 6;
  localparam int S1P = 0, S1R = 1, S2P = 2, S2R = 3, TOLD = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [WIDTH-1:0]        disp_en, dest_valid, cdb_valid, retire_en;
  logic [WIDTH-1:0][4:0]   dest_areg, src1_areg, src2_areg, retire_areg;
  logic [WIDTH-1:0][PW-1:0] free_preg, cdb_preg, retire_preg;
  logic [WIDTH-1:0][PW-1:0] src1_preg, src2_preg, told;
  logic [WIDTH-1:0]        src1_ready, src2_ready;
  logic                    rollback_en;

  typedef struct {
    int          sel;
    int          way;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rename_map_table #(.WIDTH(WIDTH), .AREG_NUM(32), .PRF_SIZE(64)) dut (
    .clock(clock), .reset(reset),
    .disp_en(disp_en), .dest_valid(dest_valid), .dest_areg(dest_areg),
    .src1_areg(src1_areg), .src2_areg(src2_areg), .free_preg(free_preg),
    .src1_preg(src1_preg), .src2_preg(src2_preg),
    .src1_ready(src1_ready), .src2_ready(src2_ready), .told(told),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
    .retire_en(retire_en), .retire_areg(retire_areg), .retire_preg(retire_preg),
    .rollback_en(rollback_en)
  );

  always #5 clock = ~clock;

  task automatic idle();
    disp_en = '0; dest_valid = '0; dest_areg = '0; src1_areg = '0; src2_areg = '0;
    free_preg = '0; cdb_valid = '0; cdb_preg = '0; retire_en = '0;
    retire_areg = '0; retire_preg = '0; rollback_en = 1'b0;
  endtask

  task automatic exp_push(input int sel, input int way, input logic [31:0] val, input string nm);
    sb.push_back('{sel, way, val, nm});
  endtask

  function automatic logic [31:0] observe(input int sel, input int way);
    case (sel)
      S1P:     observe = 32'(src1_preg[way]);
      S1R:     observe = 32'(src1_ready[way]);
      S2P:     observe = 32'(src2_preg[way]);
      S2R:     observe = 32'(src2_ready[way]);
      default: observe = 32'(told[way]);
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idle();
      src1_areg[0] = 5'(2*i);    src2_areg[0] = 5'(2*i+1);
      src1_areg[1] = 5'(31-2*i); src2_areg[1] = 5'(30-2*i);
      exp_push(S1P, 0, 2*i, "rst_src1");    exp_push(S1R, 0, 1, "rst_rdy1");
      exp_push(S2P, 0, 2*i+1, "rst_src2");  exp_push(S2R, 0, 1, "rst_rdy2");
      exp_push(S1P, 1, 31-2*i, "rst_src1"); exp_push(S2P, 1, 30-2*i, "rst_src2");
      exp_push(TOLD, 0, 0, "rst_told");     exp_push(TOLD, 1, 0, "rst_told");
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (dut.prf_ready[t] !== (t < 32)) begin
        errors++;
        $display("FAIL rst_ready tag%0d: got %b expected %b", t, dut.prf_ready[t], (t < 32));
      end
    end
  endtask

  task automatic test_dispatch();
    exp_t e;
    logic [31:0] obs;
    for (int step = 0; step < 2; step++) begin
      idle();
      case (step)
        0: begin
          disp_en[0] = 1'b1; dest_valid[0] = 1'b1; dest_areg[0] = 5'd5;
          free_preg[0] = 6'd32; src1_areg[0] = 5'd5; src1_areg[1] = 5'd6;
          exp_push(TOLD, 0, 5, "disp_told"); exp_push(S1P, 0, 5, "disp_src1");
          exp_push(S1R, 0, 1, "disp_rdy1");  exp_push(S1P, 1, 6, "disp_src1_w1");
        end
        default: begin
          src1_areg[0] = 5'd5; src2_areg[1] = 5'd5;
          exp_push(S1P, 0, 32, "disp_next_src1"); exp_push(S1R, 0, 0, "disp_next_rdy1");
          exp_push(S2P, 1, 32, "disp_next_src2"); exp_push(S2R, 1, 0, "disp_next_rdy2");
        end
      endcase
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    logic [31:0] obs;
    for (int step = 0; step < 4; step++) begin
      idle();
      case (step)
        0: begin
          disp_en = 2'b11; dest_valid = 2'b11;
          dest_areg[0] = 5'd3; free_preg[0] = 6'd33; src1_areg[0] = 5'd3;
          dest_areg[1] = 5'd3; free_preg[1] = 6'd34; src1_areg[1] = 5'd3; src2_areg[1] = 5'd5;
          exp_push(TOLD, 0, 3, "grp_told0");   exp_push(S1P, 0, 3, "grp_src1_w0");
          exp_push(S1R, 0, 1, "grp_rdy1_w0");  exp_push(S1P, 1, 33, "grp_fwd_src1");
          exp_push(S1R, 1, 0, "grp_fwd_rdy1"); exp_push(TOLD, 1, 33, "grp_fwd_told");
          exp_push(S2P, 1, 32, "grp_src2_w1"); exp_push(S2R, 1, 0, "grp_rdy2_w1");
        end
        1: begin
          disp_en = 2'b11; dest_valid = 2'b11;
          dest_areg[0] = 5'd20; free_preg[0] = 6'd46;
          dest_areg[1] = 5'd20; free_preg[1] = 6'd47; src1_areg[1] = 5'd20;
          exp_push(TOLD, 0, 20, "b2b_told0"); exp_push(TOLD, 1, 46, "b2b_told1");
          exp_push(S1P, 1, 46, "b2b_src1");   exp_push(S1R, 1, 0, "b2b_rdy1");
        end
        2: begin
          disp_en[0] = 1'b1; dest_valid[0] = 1'b1; dest_areg[0] = 5'd20; free_preg[0] = 6'd48;
          src1_areg[0] = 5'd3; src1_areg[1] = 5'd20;
          exp_push(S1P, 0, 34, "grp_next_src1"); exp_push(S1R, 0, 0, "grp_next_rdy1");
          exp_push(TOLD, 0, 47, "b2b_later_wins"); exp_push(S1P, 1, 48, "b2b_fwd2");
          exp_push(S1R, 1, 0, "b2b_fwd2_rdy");
        end
        default: begin
          src1_areg[0] = 5'd20;
          exp_push(S1P, 0, 48, "b2b_final"); exp_push(S1R, 0, 0, "b2b_final_rdy");
        end
      endcase
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_cdb_bypass();
    exp_t e;
    logic [31:0] obs;
    for (int step = 0; step < 3; step++) begin
      idle();
      case (step)
        0: begin
          cdb_valid = 2'b11; cdb_preg[0] = 6'd32; cdb_preg[1] = 6'd35;
          src1_areg[0] = 5'd5;
          disp_en[0] = 1'b1; dest_valid[0] = 1'b1; dest_areg[0] = 5'd9; free_preg[0] = 6'd35;
          src2_areg[1] = 5'd9; src1_areg[1] = 5'd3;
          exp_push(S1P, 0, 32, "cdb_src1"); exp_push(S1R, 0, 1, "cdb_bypass");
          exp_push(S2P, 1, 35, "cdb_fwd_src2"); exp_push(S2R, 1, 0, "cdb_fwd_not_rdy");
          exp_push(S1R, 1, 0, "cdb_no_hit");
        end
        1: begin
          cdb_valid[0] = 1'b1; cdb_preg[0] = 6'd34;
          src1_areg[0] = 5'd5; src2_areg[0] = 5'd9; src1_areg[1] = 5'd3;
          exp_push(S1R, 0, 1, "cdb_persist"); exp_push(S2P, 0, 35, "cdb_alloc_src2");
          exp_push(S2R, 0, 0, "cdb_alloc_wins"); exp_push(S1R, 1, 1, "cdb_bypass_w1");
        end
        default: begin
          src1_areg[1] = 5'd3;
          exp_push(S1P, 1, 34, "cdb_r3_src"); exp_push(S1R, 1, 1, "cdb_persist_w1");
        end
      endcase
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_rollback();
    exp_t e;
    logic [31:0] obs;
    for (int step = 0; step < 6; step++) begin
      idle();
      case (step)
        0: begin
          disp_en[0] = 1'b1; dest_valid[0] = 1'b1; dest_areg[0] = 5'd7; free_preg[0] = 6'd40;
          exp_push(TOLD, 0, 7, "rb_told");
        end
        1: begin
          rollback_en = 1'b1;
          disp_en[1] = 1'b1; dest_valid[1] = 1'b1; dest_areg[1] = 5'd10; free_preg[1] = 6'd44;
        end
        2: begin
          src1_areg[0] = 5'd7; src2_areg[0] = 5'd3; src1_areg[1] = 5'd10; src2_areg[1] = 5'd20;
          exp_push(S1P, 0, 7, "rb_r7");   exp_push(S1R, 0, 1, "rb_r7_rdy");
          exp_push(S2P, 0, 3, "rb_r3");   exp_push(S2R, 0, 1, "rb_r3_rdy");
          exp_push(S1P, 1, 10, "rb_discard"); exp_push(S2P, 1, 20, "rb_r20");
        end
        3: begin
          disp_en[0] = 1'b1; dest_valid[0] = 1'b1; dest_areg[0] = 5'd7; free_preg[0] = 6'd40;
          retire_en = 2'b11; retire_areg[0] = 5'd8; retire_preg[0] = 6'd42;
          retire_areg[1] = 5'd8; retire_preg[1] = 6'd43;
        end
        4: begin
          rollback_en = 1'b1;
          retire_en[0] = 1'b1; retire_areg[0] = 5'd7; retire_preg[0] = 6'd40;
        end
        default: begin
          src1_areg[0] = 5'd7; src2_areg[0] = 5'd8; src1_areg[1] = 5'd3;
          exp_push(S1P, 0, 40, "rb_retire_r7"); exp_push(S1R, 0, 1, "rb_retire_rdy");
          exp_push(S2P, 0, 43, "rb_retire_order"); exp_push(S2R, 0, 1, "rb_r8_rdy");
          exp_push(S1P, 1, 3, "rb_r3_again");
        end
      endcase
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_areg0();
    exp_t e;
    logic [31:0] obs;
    for (int step = 0; step < 2; step++) begin
      idle();
      case (step)
        0: begin
          disp_en = 2'b11; dest_valid[0] = 1'b1;
          dest_areg[0] = 5'd0; free_preg[0] = 6'd41;
          dest_areg[1] = 5'd4; free_preg[1] = 6'd42; src2_areg[1] = 5'd4;
          exp_push(TOLD, 0, 0, "r0_told");      exp_push(TOLD, 1, 0, "nonreal_told");
          exp_push(S1P, 0, 0, "r0_src1");       exp_push(S1R, 0, 1, "r0_rdy1");
          exp_push(S1P, 1, 0, "r0_no_fwd");     exp_push(S1R, 1, 1, "r0_no_fwd_rdy");
          exp_push(S2P, 1, 4, "nonreal_src2");  exp_push(S2R, 1, 1, "nonreal_rdy2");
        end
        default: begin
          src2_areg[0] = 5'd4;
          exp_push(S1P, 0, 0, "r0_after");  exp_push(S1R, 0, 1, "r0_after_rdy");
          exp_push(S2P, 0, 4, "r4_after");  exp_push(S2R, 0, 1, "r4_after_rdy");
        end
      endcase
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    logic [31:0] obs;
    for (int step = 0; step < 4; step++) begin
      idle();
      case (step)
        0: begin
          reset = 1'b1; rollback_en = 1'b1;
          disp_en[0] = 1'b1; dest_valid[0] = 1'b1; dest_areg[0] = 5'd12; free_preg[0] = 6'd45;
          retire_en[0] = 1'b1; retire_areg[0] = 5'd12; retire_preg[0] = 6'd45;
          cdb_valid[1] = 1'b1; cdb_preg[1] = 6'd50;
        end
        1: begin
          reset = 1'b0;
          src1_areg[0] = 5'd12; src2_areg[0] = 5'd7; src1_areg[1] = 5'd5;
          exp_push(S1P, 0, 12, "mrst_r12"); exp_push(S1R, 0, 1, "mrst_r12_rdy");
          exp_push(S2P, 0, 7, "mrst_r7");   exp_push(S1P, 1, 5, "mrst_r5");
        end
        2: rollback_en = 1'b1;
        default: begin
          src1_areg[0] = 5'd7; src2_areg[0] = 5'd8;
          exp_push(S1P, 0, 7, "mrst_arch_r7"); exp_push(S2P, 0, 8, "mrst_arch_r8");
        end
      endcase
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.sel, e.way);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s way%0d: got %0d expected %0d", e.nm, e.way, obs, e.val);
        end
      end
      @(posedge clock); #1;
    end
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (dut.prf_ready[t] !== (t < 32)) begin
        errors++;
        $display("FAIL mrst_ready tag%0d: got %b expected %b", t, dut.prf_ready[t], (t < 32));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_dispatch();
    test_same_cycle();
    test_cdb_bypass();
    test_rollback();
    test_areg0();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Register-rename map table between the decode/dispatch stage and the ROB/RS.
- Each dispatched instruction's destination architectural register is mapped to the physical register supplied by the free list. The table returns:
  - source physical tags with ready bits;
  - the previous mapping (Told), which the ROB later hands back to the free list at retire.
- Holds a speculative map and an architectural (retirement) map. Rollback restores the speculative map from the architectural map.

Parameters:
- WIDTH, 2, dispatch/retire/CDB ways per cycle.
- AREG_NUM, 32, architectural registers; AREG 0 is hardwired zero.
- PRF_SIZE, 64, physical registers; tag width PW = clog2(PRF_SIZE).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- disp_en  in  WIDTH  way k dispatches this cycle.
- dest_valid  in  WIDTH  way k writes a destination.
- dest_areg  in  WIDTH x 5  destination architectural register.
- src1_areg, src2_areg  in  WIDTH x 5 each  source architectural registers.
- free_preg  in  WIDTH x PW  new tag from free list, consumed in way order.
- src1_preg, src2_preg  out  WIDTH x PW each  source physical tags (combinational).
- src1_ready, src2_ready  out  WIDTH each  source value available.
- told  out  WIDTH x PW  previous mapping of dest_areg, sent to ROB.
- cdb_valid  in  WIDTH  completion broadcast valid.
- cdb_preg  in  WIDTH x PW  completed physical tag.
- retire_en  in  WIDTH  ROB retires way k, oldest first.
- retire_areg  in  WIDTH x 5  retiring destination areg.
- retire_preg  in  WIDTH x PW  retiring new tag (T).
- rollback_en  in  1  mispredict recovery.

Behaviour:
- State:
  - spec_map[AREG_NUM], arch_map[AREG_NUM], each PW bits.
  - ready[PRF_SIZE], 1 bit each.
- Reset:
  - spec_map[i] = arch_map[i] = i.
  - ready[i] = 1 for i < AREG_NUM, 0 otherwise.
  - Outputs are combinational functions of state and inputs; with all enables low after reset, told = 0 and srcX_preg = map of the presented areg.
- Destination writes:
  - A write is "real" only when disp_en[k] && dest_valid[k] && dest_areg[k] != 0.
  - Non-real ways never write the spec_map.
- Lookup is combinational, same cycle, in way order:
  - Way k source: if an earlier real way j<k writes the same areg, use free_preg[j] (highest j wins) with ready=0. Otherwise use spec_map.
  - Way k told: the same intra-group forwarding rule applies.
  - Areg 0 sources return tag 0, ready 1.
  - For a non-real way, told = 0.
- Ready bypass:
  - A source tag matching a valid cdb_preg this cycle reports ready=1, unless it was forwarded from the same group (new tag).
- Spec map update at posedge: spec_map[dest_areg[k]] <= free_preg[k] for each real way, applied in way order so the later way wins.
- Ready update at posedge:
  - Set ready[cdb_preg] for each valid CDB way.
  - Then clear ready[free_preg[k]] for each real way. Allocation clear wins on the same tag.
- Retire at posedge: arch_map[retire_areg[k]] <= retire_preg[k] in way order, later way wins; areg 0 is ignored.
- Rollback:
  - When rollback_en=1 at posedge, spec_map <= arch_map including this cycle's retirements (next-state arch map).
  - All dispatch writes that cycle are discarded.
  - All ready bits for tags in the restored map are set to 1.
  - CDB updates still apply.
  - Outputs in the rollback cycle are don't-care for the consumer; dispatch is stalled upstream.
- Reset mid-operation: reset has priority over rollback, dispatch, retire and CDB. Full reinitialisation occurs in one cycle.
- No full/empty condition. Free-list starvation is handled upstream by deasserting disp_en.

Test Plan:
- Reset then dispatch way0 dest r5, free_preg=32, src1 r5 -> told=5, src1_preg=5 ready=1. Next cycle src1 r5 -> preg 32 ready=0.
- Same-cycle dependency: way0 dest r3 tag 33, way1 src1 r3, dest r3, tag 34 -> way1 src1_preg=33 ready=0, told[1]=33. Next cycle r3 maps to 34.
- CDB bypass: r5 mapped to 32 not ready, cdb_valid[0]=1 cdb_preg=32 while way0 reads r5 -> src1_ready=1 same cycle, and ready persists next cycle.
- Rollback: dispatch r7->40, retire nothing, then rollback_en -> next cycle r7 maps to 7 ready=1. With a simultaneous retire r7/40 -> r7 maps to 40 ready=1.
- Areg 0: dest_valid dest r0 tag 41 -> spec_map unchanged, told=0, and a source r0 returns tag 0 ready=1.
- Reset asserted during a dispatch+retire+rollback cycle -> all maps identity and ready[0..31]=1, ready[32..63]=0.
